cache_fill_fsm: RTL

//  Memory-side responder to the cache/memory interface: on miss_detected, fetches the whole 16-byte block
//  (8 x 16-bit words) containing miss_address from the pipelined 4-cycle memory.

---
 rtl/cache_fill_fsm_pkg.sv | 28 ++
 rtl/cache_fill_fsm_fill_counter.sv | 46 ++++
 rtl/cache_fill_fsm.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_pkg
//   Shared definitions for the cache block-fill engine: default geometry of a
//   cache block, memory read latency and the fill state encoding. The cache
//   arrays and the cache/memory interface import the same constants so that
//   block size and state encodings stay consistent across the slice.
// ----------------------------------------------------------------------------
package cache_fill_fsm_pkg;

    // Byte-address width of the memory system.
    localparam int CFF_ADDR_W          = 16;

    // 16-bit words per cache block; a block is 2*CFF_WORDS_PER_BLOCK bytes.
    localparam int CFF_WORDS_PER_BLOCK = 8;

    // Cycles from a memory read request to memory_data_valid.
    localparam int CFF_MEM_LATENCY     = 4;

    // Byte-offset bits inside one block (low address bits cleared for base).
    localparam int CFF_BLOCK_OFFSET_W  = $clog2(2 * CFF_WORDS_PER_BLOCK);

    // Fill controller states. Encodings are shared with the interface logic.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage : cache_fill_fsm_pkg

// File: rtl/cache_fill_fsm_fill_counter.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_fill_counter
//   Width-parameterised up-counter used by the fill engine for both the
//   request index and the receive index. Synchronous clear has priority over
//   the increment enable; the asynchronous active-low reset forces zero.
//
// Ports
//   clk_i   in   1      clock, rising edge
//   rst_ni  in   1      asynchronous reset, active low
//   clr_i   in   1      synchronous clear (wins over en_i)
//   en_i    in   1      increment by one this cycle
//   cnt_o   out  WIDTH  current count
// ----------------------------------------------------------------------------
module cache_fill_fsm_fill_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : cache_fill_fsm_fill_counter

// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//   Memory-side block fill engine shared by the I- and D-cache. When the
//   interface reports a miss, the whole block containing miss_address_i is
//   read from the pipelined memory, one 16-bit word per request, and each
//   returned word is written into the cache data array. The tag/valid write
//   accompanies the final data write of the block.
//
//   The first request goes out combinationally in the miss cycle itself, so
//   with the default geometry the requests occupy cycles 0..7, data returns
//   in cycles 4..11 and fsm_busy_o is high for cycles 0..11.
//
// Ports
//   clk_i                in   1       clock, rising edge
//   rst_ni               in   1       asynchronous reset, active low
//   miss_detected_i      in   1       a cache miss is pending
//   miss_address_i       in   ADDR_W  byte address that missed
//   memory_data_valid_i  in   1       memory read data valid this cycle
//   fsm_busy_o           out  1       fill in progress; also memory enable
//   mem_req_o            out  1       read request issued this cycle
//   memory_address_o     out  ADDR_W  byte address of the 16-bit word read
//   write_data_array_o   out  1       write returned word into data array
//   write_tag_array_o    out  1       write tag/valid for the filled block
//   word_offset_o        out  IDX_W   word index for write_data_array_o
// ----------------------------------------------------------------------------
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W          = CFF_ADDR_W,
    parameter int WORDS_PER_BLOCK = CFF_WORDS_PER_BLOCK
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               miss_detected_i,
    input  logic [ADDR_W-1:0]                  miss_address_i,
    input  logic                               memory_data_valid_i,
    output logic                               fsm_busy_o,
    output logic                               mem_req_o,
    output logic [ADDR_W-1:0]                  memory_address_o,
    output logic                               write_data_array_o,
    output logic                               write_tag_array_o,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset_o
);

    // Word index width, and one extra bit on the request counter so it can
    // sit at WORDS_PER_BLOCK once every request of the block has been sent.
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int REQ_W = IDX_W + 1;
    localparam int OFF_W = $clog2(2 * WORDS_PER_BLOCK);

    localparam logic [REQ_W-1:0] REQ_END  = REQ_W'(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

    fill_state_e        state_q;
    fill_state_e        state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  base_d;
    logic [REQ_W-1:0]   req_cnt_q;
    logic [IDX_W-1:0]   rcv_cnt_q;

    logic [ADDR_W-1:0]  miss_base;
    logic [IDX_W-1:0]   req_idx;
    logic               miss_accept;
    logic               fill_done;

    // Block-aligned base of the missing address.
    assign miss_base = {miss_address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Once all requests are out the counter rests at REQ_END; keep the
    // address pointing at the last word rather than running past the block.
    assign req_idx = (req_cnt_q == REQ_END) ? IDX_LAST : req_cnt_q[IDX_W-1:0];

    assign miss_accept = (state_q == IDLE) && miss_detected_i;

    // The final data write and the tag write happen together; that same
    // cycle ends the fill and clears both counters.
    assign fill_done = write_tag_array_o;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_detected_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // Outputs are also forced low while reset is asserted, so a miss that is
    // still being presented during reset cannot raise busy or a request.
    always_comb begin
        fsm_busy_o         = 1'b0;
        mem_req_o          = 1'b0;
        memory_address_o   = '0;
        write_data_array_o = 1'b0;
        write_tag_array_o  = 1'b0;
        word_offset_o      = '0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    // First request of a fill leaves in the miss cycle.
                    if (miss_detected_i) begin
                        fsm_busy_o       = 1'b1;
                        mem_req_o        = 1'b1;
                        memory_address_o = miss_base;
                    end
                end
                FILL: begin
                    fsm_busy_o         = 1'b1;
                    mem_req_o          = (req_cnt_q != REQ_END);
                    memory_address_o   = base_q + ADDR_W'({req_idx, 1'b0});
                    write_data_array_o = memory_data_valid_i;
                    word_offset_o      = rcv_cnt_q;
                    write_tag_array_o  = memory_data_valid_i && (rcv_cnt_q == IDX_LAST);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Block base: captured on the miss that starts the fill, then held so
    // later changes on the miss inputs do not disturb the running fill.
    // ------------------------------------------------------------------
    always_comb begin
        base_d = base_q;
        if (miss_accept) begin
            base_d = miss_base;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    // ------------------------------------------------------------------
    // Request and receive counters
    // ------------------------------------------------------------------
    cache_fill_fsm_fill_counter #(
        .WIDTH (REQ_W)
    ) u_req_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (fill_done),
        .en_i   (mem_req_o),
        .cnt_o  (req_cnt_q)
    );

    cache_fill_fsm_fill_counter #(
        .WIDTH (IDX_W)
    ) u_rcv_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (fill_done),
        .en_i   (write_data_array_o),
        .cnt_o  (rcv_cnt_q)
    );

endmodule : cache_fill_fsm
